// File: rtl/icache_if.sv
// icache_if: fetch-side and refill-side signals of the instruction cache.
//   Fetch: pc_i/pc_valid_i/flush_i in; inst_o/inst_valid_o/stallreq_if out.
//   Refill: mem_req_o/mem_addr_o out (level request); mem_ack_i/mem_data_i in (ack pulse).
interface icache_if;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  // slave: the cache itself
  modport slave (
    input  pc_i, pc_valid_i, flush_i, mem_ack_i, mem_data_i,
    output inst_o, inst_valid_o, stallreq_if, mem_req_o, mem_addr_o
  );

  // master: the pipeline/memory-controller side driving the cache
  modport master (
    output pc_i, pc_valid_i, flush_i, mem_ack_i, mem_data_i,
    input  inst_o, inst_valid_o, stallreq_if, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache, one 32-bit word per line.
// Latency: hit is combinational (0 cycles); miss stalls >= 2 cycles until mem_ack_i.
// Backpressure: stallreq_if on any miss/refill; rdy=0 freezes all state.
// Ports: clk, rst (sync, active-high), rdy (chip enable), bus (icache_if.slave:
//   fetch pc_i/pc_valid_i/flush_i -> inst_o/inst_valid_o/stallreq_if, and the
//   word-refill port mem_req_o/mem_addr_o -> mem_ack_i/mem_data_i).
module icache #(
  parameter int INDEX_BITS = 7,
  localparam int TAG_BITS  = 30 - INDEX_BITS,
  localparam int LINES     = 2 ** INDEX_BITS
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  icache_if.slave  bus
);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state_q, state_d;

  logic [31:0]         data_q [LINES];
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [LINES-1:0]    valid_q;

  logic        mem_req_q;
  logic [31:0] mem_addr_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  start_refill;
  logic                  install;
  logic [31:0]           inst_d;
  logic                  inst_valid_d;
  logic                  stall_d;

  assign idx      = bus.pc_i[2 +: INDEX_BITS];
  assign pc_tag   = bus.pc_i[31 -: TAG_BITS];
  // The refill target comes from the latched request address, not pc_i,
  // so a redirect during REFILL still installs the line that was fetched.
  assign fill_idx = mem_addr_q[2 +: INDEX_BITS];
  assign fill_tag = mem_addr_q[31 -: TAG_BITS];
  assign hit      = bus.pc_valid_i & valid_q[idx] & (tag_q[idx] == pc_tag);

  // flush_i needs no action: a redirect only changes pc_i, and the outstanding
  // refill completes regardless. Byte offset bits are not part of the lookup.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.flush_i, bus.pc_i[1:0]};

  always_comb begin
    state_d      = state_q;
    inst_d       = 32'h0;
    inst_valid_d = 1'b0;
    stall_d      = 1'b0;
    start_refill = 1'b0;
    install      = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            inst_d       = data_q[idx];
            inst_valid_d = 1'b1;
          end else if (bus.pc_valid_i) begin
            stall_d      = 1'b1;
            start_refill = 1'b1;
            state_d      = REFILL;
          end
        end
        REFILL: begin
          stall_d = 1'b1;
          if (bus.mem_ack_i) begin
            install = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      valid_q    <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      if (start_refill) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= {bus.pc_i[31:2], 2'b00};
      end
      if (install) begin
        mem_req_q         <= 1'b0;
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Data and tag arrays need no reset; valid_q guards them.
  always_ff @(posedge clk) begin
    if (!rst && rdy && install) begin
      data_q[fill_idx] <= bus.mem_data_i;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

  assign bus.inst_o       = inst_d;
  assign bus.inst_valid_o = inst_valid_d;
  assign bus.stallreq_if  = stall_d;
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_addr_o   = mem_addr_q;

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the PC register and the IF/ID pipeline register, with a word-refill port to the memory controller. On a hit it returns the instruction in the same cycle. On a miss it raises `stallreq_if` to the stall controller, fetches the word, installs it and then serves the PC as a hit. It is the sole producer of `stallreq_if`.

## Interface
- `INDEX_BITS`, 7: line index width; 2^INDEX_BITS one-word lines.
- `TAG_BITS`, 30-INDEX_BITS (derived): tag = pc[31:2+INDEX_BITS].
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rdy`  in  1  chip enable; low freezes all state.
- `pc_i`  in  32  fetch address from pc_reg; pc[1:0] ignored.
- `pc_valid_i`  in  1  pc_i carries a real fetch this cycle.
- `flush_i`  in  1  pipeline redirect (branch/jump) this cycle.
- `inst_o`  out  32  instruction for pc_i.
- `inst_valid_o`  out  1  inst_o valid (hit).
- `stallreq_if`  out  1  stall request to the stall controller.
- `mem_req_o`  out  1  refill request, registered, level.
- `mem_addr_o`  out  32  refill word address {pc[31:2],2'b00}, registered.
- `mem_ack_i`  in  1  one-cycle pulse: mem_data_i valid, request done.
- `mem_data_i`  in  32  refill word.

## Operation
- Storage: data[2^INDEX_BITS]×32, tag[2^INDEX_BITS]×TAG_BITS, valid[2^INDEX_BITS]×1, all flop/regfile based with combinational read.
- hit = pc_valid_i & valid[idx] & (tag[idx]==pc tag), where idx = pc[2+INDEX_BITS-1:2].
- FSM states: IDLE, REFILL.
- IDLE:
  - hit: inst_o = data[idx], inst_valid_o=1, stallreq_if=0.
  - miss (pc_valid_i & !hit): inst_valid_o=0, stallreq_if=1. Next edge: latch mem_addr_o, mem_req_o←1, go to REFILL.
  - !pc_valid_i: inst_valid_o=0, stallreq_if=0, inst_o=0.
- REFILL:
  - stallreq_if=1, inst_valid_o=0; mem_req_o and mem_addr_o held stable.
  - mem_ack_i at an edge: write data/tag/valid at the latched address, mem_req_o←0, go to IDLE.
- flush_i in REFILL: the outstanding request is not cancelled. The line is still installed on ack (valid data), and the FSM returns to IDLE to look up the new pc_i. stallreq_if stays 1 until then.
- flush_i in IDLE: no effect on state. Lookup uses the current pc_i.
- mem_ack_i while in IDLE: ignored, no write.
- rdy=0: no state, array or output-register change. mem_ack_i seen while rdy=0 is lost, so the memory controller must share the same rdy.
- The cache is never written by stores (no coherence); self-modifying code is unsupported.

## Timing
- Reset (rst=1 at an edge): all valid bits ←0, state←IDLE, mem_req_o←0, mem_addr_o←0. While rst=1: inst_o=0, inst_valid_o=0, stallreq_if=0, regardless of pc_i.
- Hit latency: 0 cycles (combinational from pc_i).
- Miss timeline:
  - cycle N: miss detected, stallreq_if=1.
  - cycle N+1: mem_req_o=1.
  - ack in cycle K≥N+1: line written at end of K; mem_req_o=0 in K+1.
  - cycle K+1: same pc hits, stallreq_if=0.
  - Minimum penalty: 2 stall cycles (N, N+1).
- mem_req_o never drops before mem_ack_i. No second request is issued until the FSM has returned to IDLE.

## Test plan
- Reset then pc_i=0x0, pc_valid_i=1 -> stallreq_if=1 in cycle 0; mem_req_o=1, mem_addr_o=0x0 in cycle 1. Ack in cycle 3 with 0x00500093 -> cycle 4: inst_o=0x00500093, inst_valid_o=1, stallreq_if=0.
- Conflict: fill 0x0, then fetch 0x200 (same idx, INDEX_BITS=7) -> miss and refill. Then 0x0 -> miss again; 0x200 data no longer returned for 0x0.
- Flush mid-refill: miss on 0x100, assert flush_i with pc_i=0x40 before ack -> mem_addr_o stays 0x100 until ack. Next cycle 0x40 misses (new request 0x40), and a later fetch of 0x100 hits.
- rdy=0 for 3 cycles during REFILL with mem_ack_i held low -> mem_req_o/mem_addr_o stable, state unchanged. Refill completes normally after rdy returns.
- Reset mid-refill (rst in REFILL) -> next cycle mem_req_o=0, all valid cleared, previously cached 0x0 misses.
- Stray mem_ack_i in IDLE and pc_valid_i=0 -> no array write, stallreq_if=0, inst_valid_o=0.
